// File: rtl/muldiv_sched_pkg.sv
// Shared types for the mul/div scheduler: FSM state encoding and the per-slot request bundle.
package muldiv_sched_pkg;

    localparam int MD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY1 = 2'd1,
        ST_BUSY2 = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_t;

    typedef struct packed {
        logic            is_div;
        logic            sign;
        logic [MD_W-1:0] a;
        logic [MD_W-1:0] b;
    } muldiv_req_t;

endpackage

// File: rtl/muldiv_sched_if.sv
// Start/operand/result pins between the scheduler (master) and the shared multiplier/divider (slave).
interface muldiv_sched_if #(
    parameter int W = 32
);
    logic           mul_start;
    logic           mul_sign;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_ready;
    logic [2*W-1:0] mul_result;

    logic           div_start;
    logic           div_sign;
    logic           div_annul;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_ready;
    logic [2*W-1:0] div_result;

    modport master (
        output mul_start, mul_sign, mul_a, mul_b,
        input  mul_ready, mul_result,
        output div_start, div_sign, div_annul, div_a, div_b,
        input  div_ready, div_result
    );

    modport slave (
        input  mul_start, mul_sign, mul_a, mul_b,
        output mul_ready, mul_result,
        input  div_start, div_sign, div_annul, div_a, div_b,
        output div_ready, div_result
    );
endinterface

// File: rtl/muldiv_opmux.sv
// Registered operand/sign latch and one-cycle start/annul pulse generator for the two units.
module muldiv_opmux
    import muldiv_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           issue,
    input  muldiv_req_t    req,
    input  logic           annul,
    muldiv_sched_if.master unit
);

    // Operands change only when their own unit is issued, so they stay stable for the whole BUSY state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unit.mul_start <= 1'b0;
            unit.mul_sign  <= 1'b0;
            unit.mul_a     <= '0;
            unit.mul_b     <= '0;
            unit.div_start <= 1'b0;
            unit.div_sign  <= 1'b0;
            unit.div_annul <= 1'b0;
            unit.div_a     <= '0;
            unit.div_b     <= '0;
        end else begin
            unit.mul_start <= issue && !req.is_div;
            unit.div_start <= issue && req.is_div;
            unit.div_annul <= annul;
            if (issue && !req.is_div) begin
                unit.mul_sign <= req.sign;
                unit.mul_a    <= req.a;
                unit.mul_b    <= req.b;
            end
            if (issue && req.is_div) begin
                unit.div_sign <= req.sign;
                unit.div_a    <= req.a;
                unit.div_b    <= req.b;
            end
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// In-order scheduler for the shared multiplier/divider: slot 1 then slot 2, per-slot result capture, stall and flush.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int W = MD_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req1,
    input  logic           req2,
    input  logic           is_div1,
    input  logic           is_div2,
    input  logic           sign1,
    input  logic           sign2,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    input  logic [W-1:0]   a2,
    input  logic [W-1:0]   b2,
    input  logic           adv,
    input  logic           flush,
    muldiv_sched_if.master unit,
    output logic [2*W-1:0] res1,
    output logic [2*W-1:0] res2,
    output logic           res1_vld,
    output logic           res2_vld,
    output logic           stall
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BUSY1 = ST_BUSY1;
    localparam logic [1:0] S_BUSY2 = ST_BUSY2;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           cur_div;
    logic           busy;
    logic           issue;
    logic           annul;
    logic           sel_ready;
    logic [2*W-1:0] sel_result;
    muldiv_req_t    slot1;
    muldiv_req_t    slot2;
    muldiv_req_t    issue_req;

    assign slot1 = '{is_div: is_div1, sign: sign1, a: a1, b: b1};
    assign slot2 = '{is_div: is_div2, sign: sign2, a: a2, b: b2};

    assign busy       = (state == S_BUSY1) || (state == S_BUSY2);
    assign sel_ready  = cur_div ? unit.div_ready  : unit.mul_ready;
    assign sel_result = cur_div ? unit.div_result : unit.mul_result;
    assign annul      = flush && busy && cur_div;
    assign stall      = (req1 || req2) && (state != S_DONE) && !flush;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        issue_req = slot1;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req1) begin
                        state_nxt = S_BUSY1;
                        issue     = 1'b1;
                    end else if (req2) begin
                        state_nxt = S_BUSY2;
                        issue     = 1'b1;
                        issue_req = slot2;
                    end
                end
                S_BUSY1: begin
                    if (sel_ready) begin
                        if (req2) begin
                            state_nxt = S_BUSY2;
                            issue     = 1'b1;
                            issue_req = slot2;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_BUSY2: begin
                    if (sel_ready) state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (adv) state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cur_div  <= 1'b0;
            res1     <= '0;
            res2     <= '0;
            res1_vld <= 1'b0;
            res2_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) cur_div <= issue_req.is_div;
            if (flush || (state == S_DONE && adv)) begin
                res1_vld <= 1'b0;
                res2_vld <= 1'b0;
            end else if (busy && sel_ready) begin
                if (state == S_BUSY1) begin
                    res1     <= sel_result;
                    res1_vld <= 1'b1;
                end else begin
                    res2     <= sel_result;
                    res2_vld <= 1'b1;
                end
            end
        end
    end

    muldiv_opmux u_opmux (
        .clk   (clk),
        .rst   (rst),
        .issue (issue),
        .req   (issue_req),
        .annul (annul),
        .unit  (unit)
    );

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: behavioural mul/div units with variable latency and an arithmetic result/stall model.
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req1, req2, is_div1, is_div2, sign1, sign2, adv, flush;
    logic [W-1:0]   a1, b1, a2, b2;
    logic [2*W-1:0] res1, res2;
    logic           res1_vld, res2_vld, stall;

    int n_checks = 0;
    int n_fail   = 0;

    int mul_lat = 2;
    int div_lat = 3;
    int mul_cnt, div_cnt;
    int n_mul_start = 0;
    int n_div_start = 0;
    int n_annul     = 0;
    logic [63:0] mul_q, div_q;
    logic        m_div_rdy;
    logic        inj_div_rdy = 1'b0;

    always #5 clk = ~clk;

    muldiv_sched_if #(.W(W)) u ();

    muldiv_sched #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req1     (req1),
        .req2     (req2),
        .is_div1  (is_div1),
        .is_div2  (is_div2),
        .sign1    (sign1),
        .sign2    (sign2),
        .a1       (a1),
        .b1       (b1),
        .a2       (a2),
        .b2       (b2),
        .adv      (adv),
        .flush    (flush),
        .unit     (u),
        .res1     (res1),
        .res2     (res2),
        .res1_vld (res1_vld),
        .res2_vld (res2_vld),
        .stall    (stall)
    );

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'd0, a};
        xb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // Divider result is {remainder, quotient}; divide by zero yields {a, all ones}.
    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt      <= 0;
            u.mul_ready  <= 1'b0;
            u.mul_result <= '0;
        end else begin
            u.mul_ready  <= 1'b0;
            u.mul_result <= 64'hDEAD_BEEF_DEAD_BEEF;
            if (u.mul_start) begin
                if (mul_lat == 1) begin
                    u.mul_ready  <= 1'b1;
                    u.mul_result <= mul_ref(u.mul_a, u.mul_b, u.mul_sign);
                end else begin
                    mul_cnt <= mul_lat - 1;
                    mul_q   <= mul_ref(u.mul_a, u.mul_b, u.mul_sign);
                end
            end else if (mul_cnt > 0) begin
                mul_cnt <= mul_cnt - 1;
                if (mul_cnt == 1) begin
                    u.mul_ready  <= 1'b1;
                    u.mul_result <= mul_q;
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt      <= 0;
            m_div_rdy    <= 1'b0;
            u.div_result <= '0;
        end else begin
            m_div_rdy    <= 1'b0;
            u.div_result <= 64'hBAD0_BAD0_BAD0_BAD0;
            if (u.div_annul) begin
                div_cnt <= 0;
            end else if (u.div_start) begin
                if (div_lat == 1) begin
                    m_div_rdy    <= 1'b1;
                    u.div_result <= div_ref(u.div_a, u.div_b, u.div_sign);
                end else begin
                    div_cnt <= div_lat - 1;
                    div_q   <= div_ref(u.div_a, u.div_b, u.div_sign);
                end
            end else if (div_cnt > 0) begin
                div_cnt <= div_cnt - 1;
                if (div_cnt == 1) begin
                    m_div_rdy    <= 1'b1;
                    u.div_result <= div_q;
                end
            end
        end
    end

    assign u.div_ready = m_div_rdy | inj_div_rdy;

    always @(posedge clk) begin
        if (u.mul_start) n_mul_start <= n_mul_start + 1;
        if (u.div_start) n_div_start <= n_div_start + 1;
        if (u.div_annul) n_annul     <= n_annul + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: present requests, count stall cycles, check results, optionally hold DONE, then advance.
    task automatic do_txn(input string tag, input logic r1, input logic r2,
                          input logic d1, input logic d2, input logic s1, input logic s2,
                          input logic [31:0] x1, input logic [31:0] y1,
                          input logic [31:0] x2, input logic [31:0] y2, input int hold);
        logic [63:0] e1, e2;
        int exp_stall, cyc, m0, d0, exp_m, exp_d;
        e1 = d1 ? div_ref(x1, y1, s1) : mul_ref(x1, y1, s1);
        e2 = d2 ? div_ref(x2, y2, s2) : mul_ref(x2, y2, s2);
        exp_stall = 1 + (r1 ? ((d1 ? div_lat : mul_lat) + 1) : 0)
                      + (r2 ? ((d2 ? div_lat : mul_lat) + 1) : 0);
        exp_m = int'(r1 && !d1) + int'(r2 && !d2);
        exp_d = int'(r1 && d1) + int'(r2 && d2);
        m0 = n_mul_start;
        d0 = n_div_start;
        @(negedge clk);
        req1 = r1; is_div1 = d1; sign1 = s1; a1 = x1; b1 = y1;
        req2 = r2; is_div2 = d2; sign2 = s2; a2 = x2; b2 = y2;
        adv = 1'b0;
        cyc = 0;
        #1;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_stall));
        check({tag, "_res1_vld"}, 64'(res1_vld), 64'(r1));
        check({tag, "_res2_vld"}, 64'(res2_vld), 64'(r2));
        if (r1) check({tag, "_res1"}, res1, e1);
        if (r2) check({tag, "_res2"}, res2, e2);
        check({tag, "_mul_starts"}, 64'(n_mul_start - m0), 64'(exp_m));
        check({tag, "_div_starts"}, 64'(n_div_start - d0), 64'(exp_d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check({tag, "_hold_stall"}, 64'(stall), 64'd0);
            check({tag, "_hold_vld"}, {62'd0, res2_vld, res1_vld}, {62'd0, r2, r1});
            if (r1) check({tag, "_hold_res1"}, res1, e1);
            if (r2) check({tag, "_hold_res2"}, res2, e2);
            check({tag, "_hold_starts"}, 64'(n_mul_start - m0 + n_div_start - d0), 64'(exp_m + exp_d));
        end
        adv = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        req2 = 1'b0;
        adv  = 1'b0;
        #1;
        check({tag, "_adv_vld_clear"}, {62'd0, res2_vld, res1_vld}, 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_no_extra_start"}, 64'(n_mul_start - m0 + n_div_start - d0), 64'(exp_m + exp_d));
    endtask

    initial begin
        int cyc, a0, d0, sel;
        logic rr1, rr2, dd1, dd2, ss1, ss2;
        logic [31:0] x1, y1, x2, y2;

        req1 = 0; req2 = 0; is_div1 = 0; is_div2 = 0; sign1 = 0; sign2 = 0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0; adv = 0; flush = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_vld", {62'd0, res2_vld, res1_vld}, 64'd0);
        check("rst_res1", res1, 64'd0);
        check("rst_res2", res2, 64'd0);
        check("rst_starts", {62'd0, u.div_start, u.mul_start}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Signed multiply -3 * 5 with a 2-cycle multiplier: stall 4 cycles
        mul_lat = 2;
        do_txn("mul_signed", 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 0);
        check("mul_signed_literal", res1, 64'hFFFF_FFFF_FFFF_FFF1);

        // Both slots in one cycle: divide then multiply, with DONE held for 3 cycles
        div_lat = 4;
        mul_lat = 3;
        do_txn("div_then_mul", 1, 1, 1, 0, 0, 0, 32'd100, 32'd7, 32'd6, 32'd7, 3);
        check("div_then_mul_res1_literal", res1, {32'd2, 32'd14});
        check("div_then_mul_res2_literal", res2, 64'd42);

        // Flush in the second BUSY1 cycle of a divide
        div_lat = 5;
        a0 = n_annul;
        d0 = n_div_start;
        @(negedge clk);
        req1 = 1; is_div1 = 1; sign1 = 0; a1 = 32'd1000; b1 = 32'd3; req2 = 0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        req1  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("flush_annul_pulses", 64'(n_annul - a0), 64'd1);
        check("flush_div_starts", 64'(n_div_start - d0), 64'd1);
        check("flush_vld", {62'd0, res2_vld, res1_vld}, 64'd0);
        inj_div_rdy = 1'b1;
        @(negedge clk);
        inj_div_rdy = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("flush_late_ready_ignored", {62'd0, res2_vld, res1_vld}, 64'd0);
        check("flush_idle_stall", 64'(stall), 64'd0);

        // Slot 2 only, unsigned divide by zero
        div_lat = 2;
        do_txn("div_by_zero", 0, 1, 0, 1, 0, 0, 32'd0, 32'd0, 32'd1234, 32'd0, 0);
        check("div_by_zero_literal", res2, {32'd1234, 32'hFFFF_FFFF});
        check("div_by_zero_res1_vld", 64'(res1_vld), 64'd0);

        // Reset asserted during BUSY2
        mul_lat = 1;
        div_lat = 6;
        a0 = n_annul;
        @(negedge clk);
        req1 = 1; is_div1 = 0; sign1 = 1; a1 = 32'd7;          b1 = 32'd9;
        req2 = 1; is_div2 = 1; sign2 = 1; a2 = 32'hFFFF_FFCE; b2 = 32'd7;
        cyc = 0;
        while (!u.div_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached_busy2", 64'(u.div_start), 64'd1);
        check("rst_mid_res1_vld_before", 64'(res1_vld), 64'd1);
        @(negedge clk);
        #2;
        rst  = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_vld", {62'd0, res2_vld, res1_vld}, 64'd0);
        check("rst_mid_res1", res1, 64'd0);
        check("rst_mid_res2", res2, 64'd0);
        check("rst_mid_unit_ctl", {60'd0, u.div_annul, u.div_sign, u.div_start, u.mul_start}, 64'd0);
        check("rst_mid_operands", {u.div_a, u.mul_a}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_no_annul", 64'(n_annul - a0), 64'd0);
        mul_lat = 2;
        do_txn("post_rst", 1, 0, 0, 0, 0, 0, 32'd123456, 32'd789, 32'd0, 32'd0, 0);

        // Randomized transactions against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(1, 3);
            rr1 = sel[0];
            rr2 = sel[1];
            dd1 = 1'($urandom_range(0, 1));
            dd2 = 1'($urandom_range(0, 1));
            ss1 = 1'($urandom_range(0, 1));
            ss2 = 1'($urandom_range(0, 1));
            x1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
            y1 = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom());
            x2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
            y2 = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom());
            mul_lat = $urandom_range(1, 4);
            div_lat = $urandom_range(1, 6);
            do_txn("rand", rr1, rr2, dd1, dd2, ss1, ss2, x1, y1, x2, y2, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
